// File: rtl/execute_stage_if.sv
// Bundle between decode, hazard unit, forwarding sources and memory stage for execute_stage.
interface execute_stage_if #(
   parameter int DATA_W = 16,
   parameter int RID_W  = 3
);
   logic              stall;
   logic              flush;
   logic              IRegWrite;
   logic [1:0]        IRegStore;
   logic              IMemWrite;
   logic              IMemRead;
   logic [DATA_W-1:0] IPCP2;
   logic [DATA_W-1:0] IRs1Data;
   logic [DATA_W-1:0] IRs2Data;
   logic [DATA_W-1:0] IImm;
   logic              IALUSrc;
   logic [2:0]        IALUOp;
   logic [RID_W-1:0]  IRs1;
   logic [RID_W-1:0]  IRs2;
   logic [RID_W-1:0]  IRd;
   logic              memRegWrite;
   logic [RID_W-1:0]  memRd;
   logic [DATA_W-1:0] memALUResult;
   logic              wbRegWrite;
   logic [RID_W-1:0]  wbRd;
   logic [DATA_W-1:0] wbData;
   logic              ORegWrite;
   logic [1:0]        ORegStore;
   logic              OMemWrite;
   logic              OMemRead;
   logic [DATA_W-1:0] OPCP2;
   logic [DATA_W-1:0] OALUResult;
   logic [DATA_W-1:0] OThirdArg;
   logic [RID_W-1:0]  ORd;
   logic              busy;

   modport master (
      output stall, flush, IRegWrite, IRegStore, IMemWrite, IMemRead, IPCP2,
             IRs1Data, IRs2Data, IImm, IALUSrc, IALUOp, IRs1, IRs2, IRd,
             memRegWrite, memRd, memALUResult, wbRegWrite, wbRd, wbData,
      input  ORegWrite, ORegStore, OMemWrite, OMemRead, OPCP2, OALUResult,
             OThirdArg, ORd, busy
   );

   modport slave (
      input  stall, flush, IRegWrite, IRegStore, IMemWrite, IMemRead, IPCP2,
             IRs1Data, IRs2Data, IImm, IALUSrc, IALUOp, IRs1, IRs2, IRd,
             memRegWrite, memRd, memALUResult, wbRegWrite, wbRd, wbData,
      output ORegWrite, ORegStore, OMemWrite, OMemRead, OPCP2, OALUResult,
             OThirdArg, ORd, busy
   );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU with iterative shift-add multiplier.
// Define EXEC_FORWARD_EN to enable the EX/MEM and write-back forwarding muxes.
module execute_stage #(
   parameter int DATA_W = 16,
   parameter int RID_W  = 3
) (
   input logic           clk,
   input logic           reset,
   execute_stage_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_W);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

   typedef struct packed {
      logic              reg_write;
      logic [1:0]        reg_store;
      logic              mem_write;
      logic              mem_read;
      logic [DATA_W-1:0] pcp2;
      logic [DATA_W-1:0] rs1_data;
      logic [DATA_W-1:0] rs2_data;
      logic [DATA_W-1:0] imm;
      logic              alu_src;
      logic [2:0]        alu_op;
      logic [RID_W-1:0]  rs1;
      logic [RID_W-1:0]  rs2;
      logic [RID_W-1:0]  rd;
   } idex_t;

   idex_t             idex;
   idex_t             idex_next;
   mul_state_t        state;
   logic [DATA_W-1:0] mul_a;
   logic [DATA_W-1:0] mul_b;
   logic [DATA_W-1:0] acc;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] alu_result;
   logic              busy;
   logic              hold;

   assign idex_next = '{
      reg_write: bus.IRegWrite, reg_store: bus.IRegStore,
      mem_write: bus.IMemWrite, mem_read: bus.IMemRead,
      pcp2: bus.IPCP2, rs1_data: bus.IRs1Data, rs2_data: bus.IRs2Data,
      imm: bus.IImm, alu_src: bus.IALUSrc, alu_op: bus.IALUOp,
      rs1: bus.IRs1, rs2: bus.IRs2, rd: bus.IRd
   };

`ifdef EXEC_FORWARD_EN
   function automatic logic [DATA_W-1:0] forward(
      input logic [RID_W-1:0]  rs,
      input logic [DATA_W-1:0] rf_data,
      input logic              mem_we,
      input logic [RID_W-1:0]  mem_rd,
      input logic [DATA_W-1:0] mem_val,
      input logic              wb_we,
      input logic [RID_W-1:0]  wb_rd,
      input logic [DATA_W-1:0] wb_val
   );
      if (rs == '0)
         return '0;
      if (mem_we && mem_rd == rs)
         return mem_val;
      if (wb_we && wb_rd == rs)
         return wb_val;
      return rf_data;
   endfunction

   // EX/MEM result takes priority over write-back since it is the younger producer.
   assign fwd_a = forward(idex.rs1, idex.rs1_data, bus.memRegWrite, bus.memRd,
                          bus.memALUResult, bus.wbRegWrite, bus.wbRd, bus.wbData);
   assign fwd_b = forward(idex.rs2, idex.rs2_data, bus.memRegWrite, bus.memRd,
                          bus.memALUResult, bus.wbRegWrite, bus.wbRd, bus.wbData);
`else
   assign fwd_a = idex.rs1_data;
   assign fwd_b = idex.rs2_data;
`endif

   assign op_b = idex.alu_src ? idex.imm : fwd_b;
   assign busy = (state == RUN) || (state == IDLE && idex.alu_op == OP_MUL);
   assign hold = bus.stall || busy;

   always_comb begin
      alu_result = '0;
      case (idex.alu_op)
         OP_ADD:  alu_result = fwd_a + op_b;
         OP_SUB:  alu_result = fwd_a - op_b;
         OP_AND:  alu_result = fwd_a & op_b;
         OP_OR:   alu_result = fwd_a | op_b;
         OP_XOR:  alu_result = fwd_a ^ op_b;
         OP_SLL:  alu_result = fwd_a << op_b[3:0];
         OP_SRL:  alu_result = fwd_a >> op_b[3:0];
         default: alu_result = (state == DONE) ? acc : '0;
      endcase
   end

   // ID/EX register and multiplier sequencer; flush drops any multiply in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         idex  <= '0;
         state <= IDLE;
         mul_a <= '0;
         mul_b <= '0;
         acc   <= '0;
         count <= '0;
      end else if (bus.flush) begin
         idex  <= '0;
         state <= IDLE;
         acc   <= '0;
         count <= '0;
      end else begin
         if (!hold)
            idex <= idex_next;
         case (state)
            IDLE: begin
               if (idex.alu_op == OP_MUL) begin
                  mul_a <= fwd_a;
                  mul_b <= op_b;
                  acc   <= '0;
                  count <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (mul_b[0])
                  acc <= acc + mul_a;
               mul_a <= mul_a << 1;
               mul_b <= mul_b >> 1;
               count <= count + 1'b1;
               if (count == CNT_W'(DATA_W - 1))
                  state <= DONE;
            end
            DONE: begin
               if (!bus.stall)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ORegWrite  = idex.reg_write & ~busy;
   assign bus.OMemWrite  = idex.mem_write & ~busy;
   assign bus.OMemRead   = idex.mem_read & ~busy;
   assign bus.ORegStore  = idex.reg_store;
   assign bus.OPCP2      = idex.pcp2;
   assign bus.OALUResult = alu_result;
   assign bus.OThirdArg  = fwd_b;
   assign bus.ORd        = idex.rd;
   assign bus.busy       = busy;
endmodule
